c3aibadapt_rxasync_filter: RTL and testbench
============================================

C3AIBADAPT_RXASYNC_FILTER -- requirements
Module: c3aibadapt_rxasync_filter

Interface
REQ-001 Parameter SYNC_STAGES, default 2: synchronizer depth per channel; legal values are 2 or more.
REQ-002 Parameter CNT_W, default 4: width of the filter threshold and the per-channel stability counters.
REQ-003 rx_clock_async_rx_osc_clk  in  1  sole clock; all state updates on its rising edge.
REQ-004 rx_reset_async_rx_osc_clk_rst_n  in  1  reset, synchronous, active-low.
REQ-005 r_rx_async_filt_en  in  1  static config: 1 = stability filter active, 0 = bypass.
REQ-006 r_rx_async_filt_thr  in  CNT_W  static config: consecutive mismatch samples required to update an output.
REQ-007 pld_pma_rx_is_lockedtoref  in  1  PCS/PMA status, asynchronous to clock.
REQ-008 pld_pma_rx_is_lockedtodata  in  1  PCS/PMA status, asynchronous to clock.
REQ-009 pld_pma_signal_detect  in  1  PCS/PMA status, asynchronous to clock.
REQ-010 aib_hssi_pld_pma_rx_is_lockedtoref  out  1  filtered status toward AIB.
REQ-011 aib_hssi_pld_pma_rx_is_lockedtodata  out  1  filtered status toward AIB.
REQ-012 aib_hssi_pld_pma_signal_detect  out  1  filtered status toward AIB.
REQ-013 rx_async_status_chg  out  1  one-cycle pulse when any filtered output changes.
REQ-014 rx_async_chg_cnt  out  8  saturating count of change events.

Function
REQ-015 Each of the 3 channels SHALL pass through its own SYNC_STAGES-deep flop chain; no logic between stages.
REQ-016 Per channel, a mismatch SHALL mean the sync chain output differs from the registered filtered output.
REQ-017 Per channel counter: increment on a mismatch sample; clear to 0 on a match sample; clear to 0 when the output updates.
REQ-018 Effective threshold SHALL be max(r_rx_async_filt_thr, 1) when r_rx_async_filt_en=1, and exactly 1 when filt_en=0.
REQ-019 The output SHALL take the synced value on the edge that samples the N-th consecutive mismatch, where N is the effective threshold.
REQ-020 Latency from an input change captured at the first sync flop to the output change SHALL be SYNC_STAGES-1+N edges; for SYNC_STAGES=2, N=4 this is 5 edges.
REQ-021 A mismatch lasting fewer than N samples SHALL leave the output and chg_cnt unchanged.
REQ-022 If r_rx_async_filt_thr is lowered while a counter is at or above the new effective threshold, the output SHALL update on the next mismatch sample.
REQ-023 Channels SHALL filter independently; no channel's counter affects another channel.
REQ-024 rx_async_status_chg SHALL be registered and high for exactly the cycle in which the new output values are first visible; otherwise low.
REQ-025 Simultaneous updates on 2 or 3 channels SHALL produce a single pulse and a single increment.
REQ-026 rx_async_chg_cnt SHALL increment by 1 per pulse and hold at 255 (no wrap).
REQ-027 The counter width SHALL be CNT_W+1 bits so that a threshold of 2^CNT_W-1 cannot overflow.

Reset
REQ-028 While rst_n=0 at a rising edge, all sync flops, counters, filtered outputs, rx_async_status_chg and rx_async_chg_cnt SHALL become 0.
REQ-029 Reset asserted mid-filter SHALL discard partial counts; after release, a full N-sample stability window is required again.
REQ-030 After release, outputs SHALL remain 0 for at least SYNC_STAGES-1+N edges regardless of input levels.

Verification
REQ-031 Reset check: all inputs at 1, rst_n=0 for one edge -> all outputs 0, chg_cnt=0, no pulse.
REQ-032 Filtered rise: SYNC_STAGES=2, filt_en=1, thr=4, lockedtoref 0->1 held -> output rises 5 edges after first-stage capture, 1-cycle pulse, chg_cnt=1.
REQ-033 Glitch reject: thr=4, signal_detect high for 3 cycles then low -> output stays 0, no pulse, chg_cnt unchanged; the same test with thr=0 -> the glitch passes, equivalent to thr=1.
REQ-034 Bypass: filt_en=0, thr=15, lockedtodata 1->0 -> output falls after 2 edges, pulse, chg_cnt+1.
REQ-035 Simultaneous and saturation: lockedtoref and signal_detect toggle together -> one pulse, chg_cnt+1; 300 toggles -> chg_cnt=255.
REQ-036 Reset mid-filter: thr=4, counter at 2, rst_n=0 for one edge -> outputs 0; after release with the input still 1 -> rise only after the full 5-edge latency.

Source files
------------

// File: rtl/c3aibadapt_rxasync_filter.sv
// ---------------------------------------------------------------------------
// c3aibadapt_rxasync_filter
//   Synchronizes three asynchronous PCS/PMA status bits into the RX oscillator
//   clock domain and applies a per-channel stability filter. An output only
//   takes a new value after N consecutive samples disagree with it, where N is
//   the effective threshold. Any output update raises a one-cycle change pulse
//   and bumps a saturating event counter.
//
// Ports
//   rx_clock_async_rx_osc_clk            in   clock, rising edge
//   rx_reset_async_rx_osc_clk_rst_n      in   synchronous active-low reset
//   r_rx_async_filt_en                   in   1 = filter, 0 = bypass (N = 1)
//   r_rx_async_filt_thr[CNT_W-1:0]       in   mismatch samples needed to update
//   pld_pma_rx_is_lockedtoref            in   async status
//   pld_pma_rx_is_lockedtodata           in   async status
//   pld_pma_signal_detect                in   async status
//   aib_hssi_pld_pma_rx_is_lockedtoref   out  filtered status
//   aib_hssi_pld_pma_rx_is_lockedtodata  out  filtered status
//   aib_hssi_pld_pma_signal_detect       out  filtered status
//   rx_async_status_chg                  out  pulse, any filtered output changed
//   rx_async_chg_cnt[7:0]                out  saturating change-event count
// ---------------------------------------------------------------------------
module c3aibadapt_rxasync_filter #(
    parameter int SYNC_STAGES = 2,
    parameter int CNT_W       = 4
) (
    input  logic             rx_clock_async_rx_osc_clk,
    input  logic             rx_reset_async_rx_osc_clk_rst_n,
    input  logic             r_rx_async_filt_en,
    input  logic [CNT_W-1:0] r_rx_async_filt_thr,
    input  logic             pld_pma_rx_is_lockedtoref,
    input  logic             pld_pma_rx_is_lockedtodata,
    input  logic             pld_pma_signal_detect,
    output logic             aib_hssi_pld_pma_rx_is_lockedtoref,
    output logic             aib_hssi_pld_pma_rx_is_lockedtodata,
    output logic             aib_hssi_pld_pma_signal_detect,
    output logic             rx_async_status_chg,
    output logic [7:0]       rx_async_chg_cnt
);

    localparam logic [CNT_W:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W:0] CNT_ZERO = '0;

    // Channel index: 2 = lockedtoref, 1 = lockedtodata, 0 = signal_detect
    logic [2:0]                  w_in;
    logic [2:0][SYNC_STAGES-1:0] r_sync;
    logic [2:0][CNT_W:0]         r_cnt;
    logic [2:0]                  r_out;
    logic                        r_chg;
    logic [7:0]                  r_chg_cnt;

    logic [CNT_W:0]              w_thr_eff;
    logic [2:0]                  w_mis;
    logic [2:0]                  w_upd;
    logic [2:0][CNT_W:0]         w_cnt_inc;

    assign w_in = {pld_pma_rx_is_lockedtoref, pld_pma_rx_is_lockedtodata,
                   pld_pma_signal_detect};

    // A zero threshold behaves as 1 so the filter can never stall forever.
    always_comb begin
        w_thr_eff = CNT_ONE;
        if (r_rx_async_filt_en && (r_rx_async_filt_thr != '0))
            w_thr_eff = {1'b0, r_rx_async_filt_thr};
    end

    // Comparing with >= (not ==) lets a lowered threshold take effect on the
    // very next mismatch even if the count already passed it.
    always_comb begin
        w_mis     = '0;
        w_upd     = '0;
        w_cnt_inc = '0;
        for (int ch = 0; ch < 3; ch++) begin
            w_mis[ch]     = r_sync[ch][SYNC_STAGES-1] ^ r_out[ch];
            w_cnt_inc[ch] = r_cnt[ch] + CNT_ONE;
            w_upd[ch]     = w_mis[ch] && (w_cnt_inc[ch] >= w_thr_eff);
        end
    end

    always_ff @(posedge rx_clock_async_rx_osc_clk) begin
        if (!rx_reset_async_rx_osc_clk_rst_n) begin
            r_sync    <= '0;
            r_cnt     <= '0;
            r_out     <= '0;
            r_chg     <= 1'b0;
            r_chg_cnt <= '0;
        end else begin
            for (int ch = 0; ch < 3; ch++) begin
                r_sync[ch] <= {r_sync[ch][SYNC_STAGES-2:0], w_in[ch]};
                if (w_upd[ch]) begin
                    r_out[ch] <= r_sync[ch][SYNC_STAGES-1];
                    r_cnt[ch] <= CNT_ZERO;
                end else if (w_mis[ch]) begin
                    r_cnt[ch] <= w_cnt_inc[ch];
                end else begin
                    r_cnt[ch] <= CNT_ZERO;
                end
            end
            // Pulse and count share the edge that updates the outputs, so all
            // become visible in the same cycle.
            r_chg <= |w_upd;
            if ((|w_upd) && (r_chg_cnt != 8'hFF))
                r_chg_cnt <= r_chg_cnt + 8'd1;
        end
    end

    assign aib_hssi_pld_pma_rx_is_lockedtoref  = r_out[2];
    assign aib_hssi_pld_pma_rx_is_lockedtodata = r_out[1];
    assign aib_hssi_pld_pma_signal_detect      = r_out[0];
    assign rx_async_status_chg                 = r_chg;
    assign rx_async_chg_cnt                    = r_chg_cnt;

endmodule

// File: tb/tb_c3aibadapt_rxasync_filter.sv
// ---------------------------------------------------------------------------
// tb_c3aibadapt_rxasync_filter
//   Directed bench for c3aibadapt_rxasync_filter with SYNC_STAGES=2, CNT_W=4.
//   Inputs change 1 time unit after a rising edge; outputs are sampled at the
//   same point, so "tick k" below is the k-th edge after an input change and
//   tick 1 is the first-stage capture edge.
// ---------------------------------------------------------------------------
module tb_c3aibadapt_rxasync_filter;

    localparam int SYNC = 2;
    localparam int CW   = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          en;
    logic [CW-1:0] thr;
    logic          ltr, ltd, sd;
    logic          o_ltr, o_ltd, o_sd, chg;
    logic [7:0]    ccnt;
    logic [2:0]    outs;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    assign outs = {o_ltr, o_ltd, o_sd};

    c3aibadapt_rxasync_filter #(.SYNC_STAGES(SYNC), .CNT_W(CW)) dut (
        .rx_clock_async_rx_osc_clk           (clk),
        .rx_reset_async_rx_osc_clk_rst_n     (rst_n),
        .r_rx_async_filt_en                  (en),
        .r_rx_async_filt_thr                 (thr),
        .pld_pma_rx_is_lockedtoref           (ltr),
        .pld_pma_rx_is_lockedtodata          (ltd),
        .pld_pma_signal_detect               (sd),
        .aib_hssi_pld_pma_rx_is_lockedtoref  (o_ltr),
        .aib_hssi_pld_pma_rx_is_lockedtodata (o_ltd),
        .aib_hssi_pld_pma_signal_detect      (o_sd),
        .rx_async_status_chg                 (chg),
        .rx_async_chg_cnt                    (ccnt)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input logic a, input logic b, input logic c);
        ltr = a; ltd = b; sd = c;
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        en = 1'b1; thr = 4'd4;
        ltr = 1'b1; ltd = 1'b1; sd = 1'b1;
        rst_n = 1'b0;
        tick();
        n_checks++; if (outs !== 3'b000) begin n_fail++; $display("FAIL reset_outs got=%b exp=000", outs); end
        n_checks++; if (chg !== 1'b0) begin n_fail++; $display("FAIL reset_chg got=%b exp=0", chg); end
        n_checks++; if (ccnt !== 8'd0) begin n_fail++; $display("FAIL reset_cnt got=%0d exp=0", ccnt); end
        rst_n = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            tick();
            n_checks++; if (outs !== 3'b000) begin n_fail++; $display("FAIL post_reset_hold tick=%0d got=%b exp=000", i, outs); end
        end
        tick();
        n_checks++; if (outs !== 3'b111) begin n_fail++; $display("FAIL post_reset_rise got=%b exp=111", outs); end
        n_checks++; if (chg !== 1'b1) begin n_fail++; $display("FAIL post_reset_pulse got=%b exp=1", chg); end
        n_checks++; if (ccnt !== 8'd1) begin n_fail++; $display("FAIL post_reset_cnt got=%0d exp=1", ccnt); end
        tick();
        n_checks++; if (chg !== 1'b0) begin n_fail++; $display("FAIL post_reset_pulse_end got=%b exp=0", chg); end
    endtask

    task automatic test_filtered_rise();
        do_reset(1'b0, 1'b0, 1'b0);
        en = 1'b1; thr = 4'd4;
        tick(); tick();
        ltr = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            tick();
            n_checks++; if (outs !== 3'b000) begin n_fail++; $display("FAIL rise_hold tick=%0d got=%b exp=000", i, outs); end
        end
        tick();
        n_checks++; if (outs !== 3'b100) begin n_fail++; $display("FAIL rise_out got=%b exp=100", outs); end
        n_checks++; if (chg !== 1'b1) begin n_fail++; $display("FAIL rise_pulse got=%b exp=1", chg); end
        n_checks++; if (ccnt !== 8'd1) begin n_fail++; $display("FAIL rise_cnt got=%0d exp=1", ccnt); end
        tick();
        n_checks++; if (chg !== 1'b0) begin n_fail++; $display("FAIL rise_pulse_width got=%b exp=0", chg); end
        n_checks++; if (outs !== 3'b100) begin n_fail++; $display("FAIL rise_stable got=%b exp=100", outs); end
    endtask

    task automatic test_glitch();
        logic seen_out, seen_chg;
        do_reset(1'b0, 1'b0, 1'b0);
        en = 1'b1; thr = 4'd4;
        seen_out = 1'b0; seen_chg = 1'b0;
        sd = 1'b1;
        for (int i = 0; i < 13; i++) begin
            tick();
            if (i == 2) sd = 1'b0;
            seen_out |= (outs != 3'b000);
            seen_chg |= chg;
        end
        n_checks++; if (seen_out !== 1'b0) begin n_fail++; $display("FAIL glitch_out_moved got=%b exp=0", seen_out); end
        n_checks++; if (seen_chg !== 1'b0) begin n_fail++; $display("FAIL glitch_pulse got=%b exp=0", seen_chg); end
        n_checks++; if (ccnt !== 8'd0) begin n_fail++; $display("FAIL glitch_cnt got=%0d exp=0", ccnt); end

        // thr=0 acts as thr=1: the same 3-cycle glitch gets through
        thr = 4'd0;
        sd = 1'b1;
        tick(); tick();
        n_checks++; if (outs !== 3'b000) begin n_fail++; $display("FAIL thr0_early got=%b exp=000", outs); end
        tick();
        n_checks++; if (outs !== 3'b001) begin n_fail++; $display("FAIL thr0_rise got=%b exp=001", outs); end
        n_checks++; if (chg !== 1'b1) begin n_fail++; $display("FAIL thr0_rise_pulse got=%b exp=1", chg); end
        n_checks++; if (ccnt !== 8'd1) begin n_fail++; $display("FAIL thr0_rise_cnt got=%0d exp=1", ccnt); end
        sd = 1'b0;
        tick(); tick();
        n_checks++; if (outs !== 3'b001) begin n_fail++; $display("FAIL thr0_fall_early got=%b exp=001", outs); end
        tick();
        n_checks++; if (outs !== 3'b000) begin n_fail++; $display("FAIL thr0_fall got=%b exp=000", outs); end
        n_checks++; if (ccnt !== 8'd2) begin n_fail++; $display("FAIL thr0_fall_cnt got=%0d exp=2", ccnt); end
    endtask

    task automatic test_bypass();
        do_reset(1'b0, 1'b0, 1'b0);
        en = 1'b0; thr = 4'd15;
        ltd = 1'b1;
        tick(); tick(); tick(); tick();
        n_checks++; if (outs !== 3'b010) begin n_fail++; $display("FAIL bypass_setup got=%b exp=010", outs); end
        n_checks++; if (ccnt !== 8'd1) begin n_fail++; $display("FAIL bypass_setup_cnt got=%0d exp=1", ccnt); end
        ltd = 1'b0;
        tick(); tick();
        n_checks++; if (outs !== 3'b010) begin n_fail++; $display("FAIL bypass_early got=%b exp=010", outs); end
        tick();
        n_checks++; if (outs !== 3'b000) begin n_fail++; $display("FAIL bypass_fall got=%b exp=000", outs); end
        n_checks++; if (chg !== 1'b1) begin n_fail++; $display("FAIL bypass_pulse got=%b exp=1", chg); end
        n_checks++; if (ccnt !== 8'd2) begin n_fail++; $display("FAIL bypass_cnt got=%0d exp=2", ccnt); end
    endtask

    task automatic test_thr_lower();
        do_reset(1'b0, 1'b0, 1'b0);
        en = 1'b1; thr = 4'd8;
        ltr = 1'b1;
        for (int i = 0; i < 7; i++) tick();   // 5 mismatch samples counted
        n_checks++; if (outs !== 3'b000) begin n_fail++; $display("FAIL thr_lower_before got=%b exp=000", outs); end
        thr = 4'd3;
        tick();
        n_checks++; if (outs !== 3'b100) begin n_fail++; $display("FAIL thr_lower_update got=%b exp=100", outs); end
        n_checks++; if (chg !== 1'b1) begin n_fail++; $display("FAIL thr_lower_pulse got=%b exp=1", chg); end
    endtask

    task automatic test_independent();
        do_reset(1'b0, 1'b0, 1'b0);
        en = 1'b1; thr = 4'd4;
        ltr = 1'b1;
        tick(); tick();
        sd = 1'b1;
        tick(); tick(); tick(); tick();
        n_checks++; if (outs !== 3'b100) begin n_fail++; $display("FAIL indep_first got=%b exp=100", outs); end
        tick();
        n_checks++; if (outs !== 3'b100) begin n_fail++; $display("FAIL indep_mid got=%b exp=100", outs); end
        tick();
        n_checks++; if (outs !== 3'b101) begin n_fail++; $display("FAIL indep_second got=%b exp=101", outs); end
        n_checks++; if (ccnt !== 8'd2) begin n_fail++; $display("FAIL indep_cnt got=%0d exp=2", ccnt); end
    endtask

    task automatic test_simul_saturate();
        do_reset(1'b0, 1'b0, 1'b0);
        en = 1'b0; thr = 4'd0;
        ltr = 1'b1; sd = 1'b1;
        tick(); tick(); tick();
        n_checks++; if (outs !== 3'b101) begin n_fail++; $display("FAIL simul_out got=%b exp=101", outs); end
        n_checks++; if (chg !== 1'b1) begin n_fail++; $display("FAIL simul_pulse got=%b exp=1", chg); end
        n_checks++; if (ccnt !== 8'd1) begin n_fail++; $display("FAIL simul_cnt got=%0d exp=1", ccnt); end
        tick();
        n_checks++; if (chg !== 1'b0) begin n_fail++; $display("FAIL simul_pulse_width got=%b exp=0", chg); end
        // 299 more paired toggles: 300 events in total
        for (int i = 2; i <= 300; i++) begin
            ltr = ~ltr; sd = ~sd;
            tick(); tick(); tick();
            if (i == 254) begin
                n_checks++; if (ccnt !== 8'd254) begin n_fail++; $display("FAIL sat_mid got=%0d exp=254", ccnt); end
            end
        end
        tick(); tick();
        n_checks++; if (ccnt !== 8'd255) begin n_fail++; $display("FAIL sat_final got=%0d exp=255", ccnt); end
    endtask

    task automatic test_reset_mid();
        do_reset(1'b0, 1'b0, 1'b0);
        en = 1'b1; thr = 4'd4;
        ltr = 1'b1;
        tick(); tick(); tick(); tick();   // counter now at 2
        rst_n = 1'b0;
        tick();
        n_checks++; if (outs !== 3'b000) begin n_fail++; $display("FAIL rstmid_outs got=%b exp=000", outs); end
        n_checks++; if (ccnt !== 8'd0) begin n_fail++; $display("FAIL rstmid_cnt got=%0d exp=0", ccnt); end
        rst_n = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            tick();
            n_checks++; if (outs !== 3'b000) begin n_fail++; $display("FAIL rstmid_hold tick=%0d got=%b exp=000", i, outs); end
        end
        tick();
        n_checks++; if (outs !== 3'b100) begin n_fail++; $display("FAIL rstmid_rise got=%b exp=100", outs); end
        n_checks++; if (ccnt !== 8'd1) begin n_fail++; $display("FAIL rstmid_rise_cnt got=%0d exp=1", ccnt); end
    endtask

    initial begin
        rst_n = 1'b0; en = 1'b1; thr = 4'd4;
        ltr = 1'b0; ltd = 1'b0; sd = 1'b0;
        test_reset();
        test_filtered_rise();
        test_glitch();
        test_bypass();
        test_thr_lower();
        test_independent();
        test_simul_saturate();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
